// File: rtl/led_fader_pkg.sv
// Shared defaults and gamma helper for the LED fader; pure combinational, no backpressure.
// lf_gamma is only referenced when LED_FADER_GAMMA_EN is defined.
package led_fader_pkg;

    localparam int LF_PWM_BITS  = 4;
    localparam int LF_DECAY_DIV = 8;

    // Squared-brightness map with endpoints pinned and a floor of 1 so a dim LED never vanishes early.
    function automatic logic [15:0] lf_gamma(input logic [15:0] level, input int pwm_bits);
        logic [31:0] sq;
        logic [15:0] max_lvl;
        max_lvl = 16'((32'd1 << pwm_bits) - 32'd1);
        sq      = (32'(level) * 32'(level)) >> pwm_bits;
        if (level == max_lvl)
            return max_lvl;
        else if (level == 16'd0)
            return 16'd0;
        else if (sq == 32'd0)
            return 16'd1;
        else
            return sq[15:0];
    endfunction

endpackage

// File: rtl/led_fader_channel.sv
// One fader channel: sticky hit, level with linear decay, duty map, registered PWM bit (1-cycle lag).
// No backpressure; optional gamma duty map under LED_FADER_GAMMA_EN.
module led_fader_channel
    import led_fader_pkg::*;
#(
    parameter int PWM_BITS = LF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                qIn,
    input  logic                boundary,
    input  logic                decayTick,
    input  logic [PWM_BITS-1:0] pwmCnt,
    output logic                qLeds
);

    localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};

    logic                hit;
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] duty;

`ifdef LED_FADER_GAMMA_EN
    assign duty = PWM_BITS'(lf_gamma(16'(level), PWM_BITS));
`else
    assign duty = level;
`endif

    // level moves only on the boundary edge, which is also when pwmCnt wraps, so periods stay whole.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit   <= 1'b0;
            level <= '0;
            qLeds <= 1'b0;
        end else begin
            if (boundary) begin
                hit <= qIn;
                if (hit | qIn)
                    level <= MAX;
                else if (decayTick && (level != '0))
                    level <= level - PWM_BITS'(1);
            end else if (qIn) begin
                hit <= 1'b1;
            end
            qLeds <= (pwmCnt < duty);
        end
    end

endmodule

// File: rtl/led_fader.sv
// Comet-tail LED fader: shared PWM/decay counters feeding N_LEDS channels; outputs lag compare by 1 cycle.
// No backpressure (qIn sampled every cycle); LED_FADER_GAMMA_EN selects gamma-mapped duty.
module led_fader
    import led_fader_pkg::*;
#(
    parameter int N_LEDS    = 4,
    parameter int PWM_BITS  = LF_PWM_BITS,
    parameter int DECAY_DIV = LF_DECAY_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_LEDS-1:0] qIn,
    output logic [N_LEDS-1:0] qLeds,
    output logic              periodEnd
);

    localparam int DC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);
    localparam logic [DC_W-1:0]     DC_LAST  = DC_W'(DECAY_DIV - 1);

    logic [PWM_BITS-1:0] pwmCnt;
    logic [DC_W-1:0]     decayCnt;
    logic                boundary;
    logic                decayTick;

    assign boundary  = (pwmCnt == PWM_LAST);
    assign decayTick = boundary && (decayCnt == DC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwmCnt    <= '0;
            decayCnt  <= '0;
            periodEnd <= 1'b0;
        end else begin
            periodEnd <= boundary;
            if (boundary) begin
                pwmCnt   <= '0;
                decayCnt <= decayTick ? '0 : decayCnt + DC_W'(1);
            end else begin
                pwmCnt <= pwmCnt + PWM_BITS'(1);
            end
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
        led_fader_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .qIn       (qIn[i]),
            .boundary  (boundary),
            .decayTick (decayTick),
            .pwmCnt    (pwmCnt),
            .qLeds     (qLeds[i])
        );
    end

endmodule
